// File: rtl/boid_update_sequencer.sv
// Walks every boid once per start pulse: read, integrate velocity (saturated) and
// position (wrapped), then write all fields back with both accumulators cleared.
module boid_update_sequencer #(
  parameter int num_boids = 2,
  parameter int x_max     = 640 << 16,
  parameter int y_max     = 480 << 16,
  parameter int max_speed = 8 << 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  frame_count,
  output logic [$clog2(num_boids)-1:0] which_boid,
  output logic [6:0]                   wb_en,
  input  logic [31:0]                  x_rd,
  input  logic [31:0]                  y_rd,
  input  logic [31:0]                  vx_rd,
  input  logic [31:0]                  vy_rd,
  input  logic [31:0]                  vx_acc_rd,
  input  logic [31:0]                  vy_acc_rd,
  output logic [31:0]                  x_wr,
  output logic [31:0]                  y_wr,
  output logic [31:0]                  vx_wr,
  output logic [31:0]                  vy_wr,
  output logic [31:0]                  vx_acc_wr,
  output logic [31:0]                  vy_acc_wr
);

  localparam int IW = $clog2(num_boids);
  localparam logic [IW-1:0] LAST_IDX = IW'(num_boids - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_COMPUTE, S_WRITE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   frame_q, frame_d;

  logic [27:0]        x_cap_q;
  logic [26:0]        y_cap_q;
  logic [20:0]        vx_cap_q, vy_cap_q;
  logic signed [31:0] vx_acc_q, vy_acc_q;

  logic [31:0] x_wr_q, y_wr_q, vx_wr_q, vy_wr_q, vx_acc_wr_q, vy_acc_wr_q;

  logic signed [31:0] vx_s, vy_s, vx_n, vy_n, x_n, y_n;

  // Only the low fixed-point bits of the padded read ports carry data.
  logic unused_bits;
  assign unused_bits = ^{x_rd[31:28], y_rd[31:27], vx_rd[31:21], vy_rd[31:21]};

  function automatic logic signed [31:0] sat(input logic signed [31:0] v);
    if (v > max_speed)  return max_speed;
    if (v < -max_speed) return -max_speed;
    return v;
  endfunction

  // Velocity magnitude is below the bound, so one correction always lands in range.
  function automatic logic signed [31:0] wrap(input logic signed [31:0] p, input int bound);
    if (p >= bound) return p - bound;
    if (p < 0)      return p + bound;
    return p;
  endfunction

  always_comb begin
    vx_s = {{11{vx_cap_q[20]}}, vx_cap_q};
    vy_s = {{11{vy_cap_q[20]}}, vy_cap_q};
    vx_n = sat(vx_s + vx_acc_q);
    vy_n = sat(vy_s + vy_acc_q);
    x_n  = wrap(signed'({4'b0000, x_cap_q}) + vx_n, x_max);
    y_n  = wrap(signed'({5'b00000, y_cap_q}) + vy_n, y_max);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          idx_d   = '0;
        end
      end
      S_READ:    state_d = S_COMPUTE;
      S_COMPUTE: state_d = S_WRITE;
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_READ;
        end
      end
      S_DONE: begin
        frame_d = frame_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    wb_en = 7'h00;
    case (state_q)
      S_READ, S_COMPUTE: busy = 1'b1;
      S_WRITE: begin
        busy  = 1'b1;
        wb_en = 7'h7F;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Read capture and the computed write-back values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cap_q     <= '0;
      y_cap_q     <= '0;
      vx_cap_q    <= '0;
      vy_cap_q    <= '0;
      vx_acc_q    <= '0;
      vy_acc_q    <= '0;
      x_wr_q      <= '0;
      y_wr_q      <= '0;
      vx_wr_q     <= '0;
      vy_wr_q     <= '0;
      vx_acc_wr_q <= '0;
      vy_acc_wr_q <= '0;
    end else if (state_q == S_READ) begin
      x_cap_q  <= x_rd[27:0];
      y_cap_q  <= y_rd[26:0];
      vx_cap_q <= vx_rd[20:0];
      vy_cap_q <= vy_rd[20:0];
      vx_acc_q <= vx_acc_rd;
      vy_acc_q <= vy_acc_rd;
    end else if (state_q == S_COMPUTE) begin
      x_wr_q      <= x_n;
      y_wr_q      <= y_n;
      vx_wr_q     <= vx_n;
      vy_wr_q     <= vy_n;
      vx_acc_wr_q <= '0;
      vy_acc_wr_q <= '0;
    end
  end

  assign frame_count = frame_q;
  assign which_boid  = idx_q;
  assign x_wr        = x_wr_q;
  assign y_wr        = y_wr_q;
  assign vx_wr       = vx_wr_q;
  assign vy_wr       = vy_wr_q;
  assign vx_acc_wr   = vx_acc_wr_q;
  assign vy_acc_wr   = vy_acc_wr_q;

endmodule

// File: tb/tb_boid_update_sequencer.sv
// Scoreboarded bench: a behavioural boid memory, a reference integrator and
// per-cycle timing checks around each update pass.
module tb_boid_update_sequencer;

  localparam int NB = 2;
  localparam int XM = 640 << 16;
  localparam int YM = 480 << 16;
  localparam int MS = 8 << 16;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done;
  logic [15:0] frame_count;
  logic [0:0]  which_boid;
  logic [6:0]  wb_en;
  logic [31:0] x_rd, y_rd, vx_rd, vy_rd, vx_acc_rd, vy_acc_rd;
  logic [31:0] x_wr, y_wr, vx_wr, vy_wr, vx_acc_wr, vy_acc_wr;

  always #5 clk = ~clk;

  boid_update_sequencer #(
    .num_boids(NB), .x_max(XM), .y_max(YM), .max_speed(MS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .frame_count(frame_count), .which_boid(which_boid), .wb_en(wb_en),
    .x_rd(x_rd), .y_rd(y_rd), .vx_rd(vx_rd), .vy_rd(vy_rd),
    .vx_acc_rd(vx_acc_rd), .vy_acc_rd(vy_acc_rd),
    .x_wr(x_wr), .y_wr(y_wr), .vx_wr(vx_wr), .vy_wr(vy_wr),
    .vx_acc_wr(vx_acc_wr), .vy_acc_wr(vy_acc_wr)
  );

  // Behavioural boid memory: combinational read, write on wb_en, preload when idle.
  logic [31:0] m_x[NB], m_y[NB], m_vx[NB], m_vy[NB], m_ax[NB], m_ay[NB];
  logic        ld_en = 1'b0;
  int          ld_idx = 0;
  logic [31:0] ld_v[6];

  assign x_rd      = m_x[which_boid];
  assign y_rd      = m_y[which_boid];
  assign vx_rd     = m_vx[which_boid];
  assign vy_rd     = m_vy[which_boid];
  assign vx_acc_rd = m_ax[which_boid];
  assign vy_acc_rd = m_ay[which_boid];

  always @(posedge clk) begin
    if (wb_en[0]) begin
      if (wb_en[1]) m_x[which_boid]  <= x_wr;
      if (wb_en[2]) m_y[which_boid]  <= y_wr;
      if (wb_en[3]) m_vx[which_boid] <= vx_wr;
      if (wb_en[4]) m_vy[which_boid] <= vy_wr;
      if (wb_en[5]) m_ax[which_boid] <= vx_acc_wr;
      if (wb_en[6]) m_ay[which_boid] <= vy_acc_wr;
    end else if (ld_en) begin
      m_x[ld_idx]  <= ld_v[0];
      m_y[ld_idx]  <= ld_v[1];
      m_vx[ld_idx] <= ld_v[2];
      m_vy[ld_idx] <= ld_v[3];
      m_ax[ld_idx] <= ld_v[4];
      m_ay[ld_idx] <= ld_v[5];
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  int n_writes = 0;
  int n_done   = 0;
  logic [15:0] exp_fc = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the integration rules.
  function automatic int new_vel(input logic [31:0] raw, input logic [31:0] acc);
    int v;
    v = raw << 11;
    v = v >>> 11;
    v = v + int'(acc);
    if (v > MS)  v = MS;
    if (v < -MS) v = -MS;
    return v;
  endfunction

  function automatic logic [31:0] new_pos(input logic [31:0] raw, input logic [31:0] mask,
                                          input int v, input int bound);
    longint p;
    longint b;
    p = raw & mask;
    b = bound;
    p = p + v;
    return 32'(((p % b) + b) % b);
  endfunction

  typedef struct {
    int          idx;
    logic [31:0] x, y, vx, vy;
  } exp_t;

  exp_t sb_q[$];

  // Monitor: every write the DUT presents is popped from the scoreboard and compared.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && wb_en != 7'h00) begin
      n_writes++;
      $display("write boid %0d x=%h y=%h vx=%h vy=%h", which_boid, x_wr, y_wr, vx_wr, vy_wr);
      if (sb_q.size() == 0) begin
        check("unexpected_write", 32'(wb_en), 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("wr_index", 32'(which_boid), 32'(e.idx));
        check("x_wr", x_wr, e.x);
        check("y_wr", y_wr, e.y);
        check("vx_wr", vx_wr, e.vx);
        check("vy_wr", vy_wr, e.vy);
        check("vx_acc_wr", vx_acc_wr, 32'h0);
        check("vy_acc_wr", vy_acc_wr, 32'h0);
      end
    end
    if (!reset && done) n_done++;
  end

  task automatic load_boid(input int i, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] vx, input logic [31:0] vy,
                           input logic [31:0] ax, input logic [31:0] ay);
    ld_idx  = i;
    ld_v[0] = x;  ld_v[1] = y;  ld_v[2] = vx;
    ld_v[3] = vy; ld_v[4] = ax; ld_v[5] = ay;
    ld_en   = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic push_expected();
    exp_t e;
    int   vxn, vyn;
    for (int k = 0; k < NB; k++) begin
      vxn  = new_vel(m_vx[k], m_ax[k]);
      vyn  = new_vel(m_vy[k], m_ay[k]);
      e.idx = k;
      e.vx  = vxn;
      e.vy  = vyn;
      e.x   = new_pos(m_x[k], 32'h0FFF_FFFF, vxn, XM);
      e.y   = new_pos(m_y[k], 32'h07FF_FFFF, vyn, YM);
      sb_q.push_back(e);
    end
  endtask

  // One full pass with the cycle schedule checked; optional stray start in cycle 4.
  task automatic run_pass(input bit extra_start);
    int nw0, nd0;
    nw0 = n_writes;
    nd0 = n_done;
    push_expected();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 3 * NB + 2; c++) begin
      @(negedge clk);
      check($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= 3 * NB));
      check($sformatf("done_c%0d", c), 32'(done), 32'(c == 3 * NB + 1));
      check($sformatf("wb_en_c%0d", c), 32'(wb_en),
            (c <= 3 * NB && c % 3 == 0) ? 32'h7F : 32'h0);
      if (c <= 3 * NB) check($sformatf("which_boid_c%0d", c), 32'(which_boid), 32'((c - 1) / 3));
      if (extra_start && c == 4) start = 1'b1;
      if (extra_start && c == 5) start = 1'b0;
    end
    exp_fc = exp_fc + 16'd1;
    check("frame_count", 32'(frame_count), 32'(exp_fc));
    check("writes_per_pass", 32'(n_writes - nw0), 32'(NB));
    check("dones_per_pass", 32'(n_done - nd0), 32'd1);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] sv_x1, sv_y1;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_frame_count", 32'(frame_count), 32'h0);
    check("rst_which_boid", 32'(which_boid), 32'h0);
    check("rst_wb_en", 32'(wb_en), 32'h0);
    check("rst_x_wr", x_wr, 32'h0);
    check("rst_y_wr", y_wr, 32'h0);
    check("rst_vx_wr", vx_wr, 32'h0);
    check("rst_vy_wr", vy_wr, 32'h0);
    check("rst_vx_acc_wr", vx_acc_wr, 32'h0);
    check("rst_vy_acc_wr", vy_acc_wr, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Basic integrate on boid0, saturation both directions on boid1.
    load_boid(0, 120 << 16, 120 << 16, 5 << 16, 4 << 16, 32'h0, 32'h0);
    load_boid(1, 100 << 16, 100 << 16, 7 << 16, 32'hFFF9_0000, 3 << 16, 32'hFFFD_0000);
    run_pass(1'b0);
    @(posedge clk);
    #1;
    check("basic_x", m_x[0], 125 << 16);
    check("basic_y", m_y[0], 124 << 16);
    check("basic_vx", m_vx[0], 5 << 16);
    check("basic_vy", m_vy[0], 4 << 16);
    check("basic_acc", m_ax[0] | m_ay[0], 32'h0);
    check("sat_vx", m_vx[1], 8 << 16);
    check("sat_vy", m_vy[1], 32'hFFF8_0000);
    check("sat_acc", m_ax[1] | m_ay[1], 32'h0);

    // Wrap on both axes, with a stray start that must be ignored.
    load_boid(0, 638 << 16, 10 << 16, 5 << 16, 32'h0, 32'h0, 32'h0);
    load_boid(1, 10 << 16, 2 << 16, 32'h0, 32'hFFFB_0000, 32'h0, 32'h0);
    run_pass(1'b1);
    @(posedge clk);
    #1;
    check("wrap_x", m_x[0], 3 << 16);
    check("wrap_y", m_y[1], 477 << 16);

    // Reset in cycle 4 aborts before boid1 is written.
    sv_x1 = m_x[1];
    sv_y1 = m_y[1];
    push_expected();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_wb_en", 32'(wb_en), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_frame_count", 32'(frame_count), 32'h0);
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    check("abort_pending_writes", 32'(sb_q.size()), 32'd1);
    sb_q.delete();
    exp_fc = 16'd0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_boid1_x", m_x[1], sv_x1);
    check("abort_boid1_y", m_y[1], sv_y1);
    check("abort_idle_busy", 32'(busy), 32'h0);
    run_pass(1'b0);

    // Randomized passes with junk in the padding bits.
    for (int it = 0; it < 16; it++) begin
      for (int k = 0; k < NB; k++) begin
        load_boid(k,
                  ($urandom() & 32'hF000_0000) | $urandom_range(XM - 1),
                  ($urandom() & 32'hF800_0000) | $urandom_range(YM - 1),
                  $urandom(), $urandom(),
                  $urandom_range(24 << 16) - (12 << 16),
                  $urandom_range(24 << 16) - (12 << 16));
      end
      run_pass(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
